// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0, CPHA=0) SPI master, one DATA_WIDTH-bit word per transfer,
// MSB first in both directions.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   start    transfer request, sampled only while busy=0
//   tx_data  word to send, captured on the edge that accepts start
//   busy     high from acceptance until the end of the CS-high gap
//   done     one-cycle pulse when the transfer completes
//   rx_data  received word, updated with done and held until the next done
//   sck      SPI clock, idles low
//   cs       chip select, active low, idles high
//   mosi     serial data out
//   miso     serial data in, already synchronous to clk
//
// Every output is a flop; nothing combinational reaches a port.
// Timeline per transfer (D = CLK_DIV, W = DATA_WIDTH, E0 = accepting edge):
//   SETUP D cycles, then W x (HIGH D, LOW D), where the last low half-period is HOLD,
//   then GAP D cycles with cs high. done fires on entry to GAP at E0+(2W+1)D.

module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sck,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned PhW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BcW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  state_e                state_q;
  logic [PhW-1:0]        phase_q;
  logic [BcW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;

  logic                  phase_last;
  logic                  bit_last;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;

  always_comb begin
    phase_last = (phase_q == PhW'(CLK_DIV - 1));
    bit_last   = (bit_cnt_q == BcW'(DATA_WIDTH - 1));
    tx_shift   = tx_q << 1;
    rx_shift   = (rx_q << 1) | DATA_WIDTH'(miso);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      sck       <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Phase counter runs in every active state and wraps at each half-period boundary.
      if (state_q != StIdle) begin
        phase_q <= phase_last ? '0 : phase_q + PhW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StSetup;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= tx_data;
            rx_q      <= '0;
            busy      <= 1'b1;
            cs        <= 1'b0;
            mosi      <= tx_data[DATA_WIDTH-1];
          end
        end

        StSetup: begin
          if (phase_last) begin
            state_q <= StHigh;
            sck     <= 1'b1;
            rx_q    <= rx_shift;
          end
        end

        StHigh: begin
          if (phase_last) begin
            sck <= 1'b0;
            if (bit_last) begin
              // Final falling edge: no shift, mosi keeps bit 0, and the last low
              // half-period doubles as the CS hold time.
              state_q <= StHold;
            end else begin
              state_q   <= StLow;
              tx_q      <= tx_shift;
              mosi      <= tx_shift[DATA_WIDTH-1];
              bit_cnt_q <= bit_cnt_q + BcW'(1);
            end
          end
        end

        StLow: begin
          if (phase_last) begin
            state_q <= StHigh;
            sck     <= 1'b1;
            rx_q    <= rx_shift;
          end
        end

        StHold: begin
          if (phase_last) begin
            state_q <= StGap;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_q;
            done    <= 1'b1;
          end
        end

        StGap: begin
          if (phase_last) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master. Instance a is W=8, D=2 with either a
// loopback or a mode-0 slave model on miso; instance b is W=16, D=1 in loopback.

module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, busy_a, done_a, sck_a, cs_a, mosi_a, miso_a;
  logic [7:0]  tx_a, rx_a;
  logic        start_b, busy_b, done_b, sck_b, cs_b, mosi_b;
  logic [15:0] tx_b, rx_b;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .start   (start_a),
    .tx_data (tx_a),
    .busy    (busy_a),
    .done    (done_a),
    .rx_data (rx_a),
    .sck     (sck_a),
    .cs      (cs_a),
    .mosi    (mosi_a),
    .miso    (miso_a)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .start   (start_b),
    .tx_data (tx_b),
    .busy    (busy_b),
    .done    (done_b),
    .rx_data (rx_b),
    .sck     (sck_b),
    .cs      (cs_b),
    .mosi    (mosi_b),
    .miso    (mosi_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0;

  always @(posedge clk) cyc++;

  // Mode-0 slave model: presents MSB when cs falls, shifts out on sck fall, captures on rise.
  logic       use_slave = 1'b0;
  logic [7:0] slv_word = 8'h00;
  logic [7:0] slv_out = 8'h00;
  logic [7:0] slv_cap = 8'h00;

  always @(negedge cs_a) begin
    slv_out = slv_word;
    slv_cap = 8'h00;
  end
  always @(posedge sck_a) if (!cs_a) slv_cap = {slv_cap[6:0], mosi_a};
  always @(negedge sck_a) if (!cs_a) slv_out = {slv_out[6:0], 1'b0};

  assign miso_a = use_slave ? slv_out[7] : mosi_a;

  // Line monitor on instance a; counters are monotonic, tests work on differences.
  logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;
  int rises = 0, cs_low = 0, done_cnt = 0, violations = 0, acc_n = 0, gap_n = 0;
  int t_csr = -1;
  int acc_t[64];
  int gap_t[64];
  logic [7:0] done_rx[64];

  always @(negedge clk) begin
    if (!cs_a) cs_low++;
    if (sck_a && !p_sck) begin
      rises++;
      if (mosi_a !== p_mosi) violations++;
    end
    if ((cs_a !== p_cs) && (sck_a || p_sck)) violations++;
    if (done_a) begin
      if (done_cnt < 64) done_rx[done_cnt] = rx_a;
      done_cnt++;
    end
    if (busy_a && !p_busy) begin
      if (acc_n < 64) acc_t[acc_n] = cyc;
      acc_n++;
    end
    if (cs_a && !p_cs) t_csr = cyc;
    if (!cs_a && p_cs && t_csr >= 0) begin
      if (gap_n < 64) gap_t[gap_n] = cyc - t_csr;
      gap_n++;
    end
    p_sck  = sck_a;
    p_cs   = cs_a;
    p_mosi = mosi_a;
    p_busy = busy_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transfer on instance a; latencies are edge offsets from E0, -1 on timeout.
  task automatic xfer_a(input logic [7:0] tx, input logic slave, input logic [7:0] sw,
                        output int lat_done, output logic done_after, output int lat_idle);
    int n;
    @(negedge clk);
    use_slave = slave;
    slv_word  = sw;
    tx_a      = tx;
    start_a   = 1'b1;
    e0        = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat_done = done_a ? cyc - e0 : -1;
    @(negedge clk);
    done_after = done_a;
    n = 0;
    while (busy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat_idle = busy_a ? -1 : cyc - e0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       slave;
    logic [7:0] sw;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   ld, li, r0, c0, v0, d0, a0, g0, n;
    logic da;

    vecs[0] = '{tx: 8'hA5, slave: 1'b0, sw: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hC3, slave: 1'b1, sw: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, slave: 1'b0, sw: 8'h00, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'hFF, slave: 1'b1, sw: 8'h81, exp_rx: 8'h81};

    // Reset with start held high: start must be dropped.
    reset   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    tx_a    = 8'h96;
    tx_b    = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_cs", cs_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rx", rx_a, 0);
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", busy_a, 0);

    // Table-driven single transfers.
    for (int i = 0; i < 4; i++) begin
      r0 = rises;
      c0 = cs_low;
      v0 = violations;
      xfer_a(vecs[i].tx, vecs[i].slave, vecs[i].sw, ld, da, li);
      check($sformatf("v%0d_rx", i), rx_a, vecs[i].exp_rx);
      check($sformatf("v%0d_done_lat", i), ld, 34);
      check($sformatf("v%0d_done_pulse", i), da, 0);
      check($sformatf("v%0d_idle_lat", i), li, 36);
      check($sformatf("v%0d_sck_rises", i), rises - r0, 8);
      check($sformatf("v%0d_cs_low", i), cs_low - c0, 34);
      check($sformatf("v%0d_slave_cap", i), slv_cap, vecs[i].tx);
      check($sformatf("v%0d_line_rules", i), violations - v0, 0);
    end

    // start pulsed mid-transfer with a new tx_data: ignored.
    d0 = done_cnt;
    @(negedge clk);
    use_slave = 1'b0;
    tx_a      = 8'h12;
    start_a   = 1'b1;
    e0        = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    tx_a    = 8'hFF;
    while (cyc - e0 < 4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc - e0 < 19) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("ign_done_count", done_cnt - d0, 1);
    check("ign_rx", rx_a, 8'h12);
    check("ign_slave_cap", slv_cap, 8'h12);
    check("ign_no_requeue", busy_a, 0);

    // start held for three back-to-back transfers.
    a0 = acc_n;
    d0 = done_cnt;
    g0 = gap_n;
    @(negedge clk);
    tx_a    = 8'h01;
    start_a = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (acc_n - a0 == 1) tx_a = 8'h80;
      if (acc_n - a0 == 2) tx_a = 8'h7E;
      if (acc_n - a0 >= 3) break;
    end
    start_a = 1'b0;
    n = 0;
    while ((done_cnt - d0 < 3 || busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_accepts", acc_n - a0, 3);
    check("held_acc1", acc_t[a0+1] - acc_t[a0], 37);
    check("held_acc2", acc_t[a0+2] - acc_t[a0], 74);
    check("held_rx0", done_rx[d0], 8'h01);
    check("held_rx1", done_rx[d0+1], 8'h80);
    check("held_rx2", done_rx[d0+2], 8'h7E);
    check("held_gap1", gap_t[g0+1], 3);
    check("held_gap2", gap_t[g0+2], 3);

    // Reset at E0+13 aborts the transfer.
    d0 = done_cnt;
    @(negedge clk);
    tx_a    = 8'h33;
    start_a = 1'b1;
    e0      = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc - e0 < 12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", cs_a, 1);
    check("abort_sck", sck_a, 0);
    check("abort_mosi", mosi_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_rx", rx_a, 0);
    check("abort_done", done_a, 0);
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    xfer_a(8'h5A, 1'b0, 8'h00, ld, da, li);
    check("after_abort_rx", rx_a, 8'h5A);
    check("after_abort_lat", ld, 34);

    // W=16, D=1 loopback.
    @(negedge clk);
    tx_b    = 16'hBEEF;
    start_b = 1'b1;
    e0      = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("w16_done_lat", done_b ? cyc - e0 : -1, 33);
    check("w16_rx", rx_b, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
